// File: rtl/cmp_share_ctrl.sv
// cmp_share_ctrl: round-robin sharing of one magnitude comparator among NUM_REQ requesters.
// Define CMP_SIGNED_EN to add the req_signed port for two's-complement compares.
module cmp_share_ctrl #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH = 18,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef CMP_SIGNED_EN
  input  logic [NUM_REQ-1:0]       req_signed,
`endif
  output logic [WIDTH-1:0]         cmp_a,
  output logic [WIDTH-1:0]         cmp_b,
  input  logic                     cmp_gt,
  input  logic                     cmp_lt,
  input  logic                     cmp_eq,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_gt,
  output logic                     rsp_lt,
  output logic                     rsp_eq
);
  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;
  state_t state, state_next;
  logic [ID_W-1:0] rr_ptr, win;
  logic [NUM_REQ-1:0] rot;
  logic found;
  logic [WIDTH-1:0] flip;
  // rot[k] is the request k places after rr_ptr; scanning downward leaves the nearest one
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    win = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) begin
        win = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
  end
`ifdef CMP_SIGNED_EN
  // inverting the sign bits maps two's-complement order onto unsigned order
  assign flip = {req_signed[win], {(WIDTH-1){1'b0}}};
`else
  assign flip = '0;
`endif
  always_comb begin
    state_next = state;
    req_ready = '0;
    if (state == IDLE && found) begin
      state_next = CMP;
      req_ready[win] = 1'b1;
    end else if (state == CMP) state_next = RESP;
    else if (state == RESP && rsp_ready) state_next = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk)
    if (rst) begin
      rr_ptr <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
      rsp_id <= '0;
      rsp_valid <= 1'b0;
      {rsp_gt, rsp_lt, rsp_eq} <= '0;
    end else begin
      if (state == IDLE && found) begin
        cmp_a <= req_a[win*WIDTH +: WIDTH] ^ flip;
        cmp_b <= req_b[win*WIDTH +: WIDTH] ^ flip;
        rsp_id <= win;
      end
      if (state == CMP) begin
        {rsp_gt, rsp_lt, rsp_eq} <= {cmp_gt, cmp_lt, cmp_eq};
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
      end
    end
endmodule

// File: tb/tb_cmp_share_ctrl.sv
// tb_cmp_share_ctrl: directed and randomized checks of cmp_share_ctrl against a transaction-level model.
module tb_cmp_share_ctrl;
  localparam int N = 3;
  localparam int W = 18;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
`ifdef CMP_SIGNED_EN
  logic [N-1:0] req_signed;
`endif
  logic [W-1:0] cmp_a, cmp_b;
  logic cmp_gt, cmp_lt, cmp_eq;
  logic rsp_valid, rsp_ready, rsp_gt, rsp_lt, rsp_eq;
  logic [IW-1:0] rsp_id;
  logic [2:0] fmask;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // the shared comparator, with an injectable flag corruption
  assign {cmp_gt, cmp_lt, cmp_eq} = {cmp_a > cmp_b, cmp_a < cmp_b, cmp_a == cmp_b} ^ fmask;

  cmp_share_ctrl #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef CMP_SIGNED_EN
    .req_signed(req_signed),
`endif
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq)
  );

  // transaction model: m_age -1 = nothing in flight, 0 = compare cycle, 1 = response offered
  int m_ptr, m_age, m_rid, w_cur, last_grant, cyc;
  logic m_valid, m_rs;
  logic [2:0] m_rflags;
  logic [W-1:0] m_ca, m_cb, m_ra, m_rb;
  int waitc [N];
  int gl[$];
  int gc[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lat(input logic [W-1:0] v, input logic s);
    return s ? {~v[W-1], v[W-2:0]} : v;
  endfunction

  function automatic logic [2:0] cmpf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (s) return {$signed(a) > $signed(b), $signed(a) < $signed(b), a == b};
    return {a > b, a < b, a == b};
  endfunction

  function automatic logic sgn(input int i);
`ifdef CMP_SIGNED_EN
    return req_signed[i];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_age = -1; m_valid = 0; m_rid = 0; m_rflags = 0;
    m_ca = 0; m_cb = 0; last_grant = -1;
    for (int i = 0; i < N; i++) waitc[i] = 0;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic sample();
    #1;
    w_cur = -1;
    if (m_age < 0)
      for (int k = 0; k < N; k++)
        if (w_cur < 0 && req_valid[(m_ptr + k) % N]) w_cur = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) if (!req_valid[i]) waitc[i] = 0;
    chk("req_ready", req_ready, (w_cur < 0) ? 0 : (1 << w_cur));
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_id", rsp_id, m_rid);
    chk("rsp_flags", {rsp_gt, rsp_lt, rsp_eq}, m_rflags);
    chk("cmp_a", cmp_a, m_ca);
    chk("cmp_b", cmp_b, m_cb);
  endtask

  task automatic advance();
    if (rst) model_reset();
    else begin
      last_grant = w_cur;
      if (m_age == 0) begin
        m_rflags = cmpf(m_ra, m_rb, m_rs) ^ fmask;
        m_valid = 1;
        m_age = 1;
      end else if (m_age >= 1) begin
        if (rsp_ready) begin
          m_valid = 0;
          m_ptr = (m_rid + 1) % N;
          m_age = -1;
        end
      end else if (w_cur >= 0) begin
        m_rid = w_cur;
        m_ra = req_a[w_cur*W +: W];
        m_rb = req_b[w_cur*W +: W];
        m_rs = sgn(w_cur);
        m_ca = lat(m_ra, m_rs);
        m_cb = lat(m_rb, m_rs);
        m_age = 0;
        gl.push_back(w_cur);
        gc.push_back(cyc);
        for (int i = 0; i < N; i++)
          if (i != w_cur && req_valid[i]) begin
            waitc[i]++;
            chk("fairness", waitc[i] < N, 1);
          end
        waitc[w_cur] = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin sample(); advance(); end
  endtask

  task automatic do_reset();
    rst = 1;
    req_valid = 0;
    sample();
    advance();
    rst = 0;
  endtask

  task automatic new_ops(input int i);
    logic [W-1:0] a, b;
    a = W'($urandom_range(0, (1 << W) - 1));
    b = ($urandom_range(3) == 0) ? a : W'($urandom_range(0, (1 << W) - 1));
    set_ops(i, a, b);
`ifdef CMP_SIGNED_EN
    req_signed[i] = $urandom_range(1) == 1;
`endif
  endtask

  initial begin
    cyc = 0;
    rst = 1; req_valid = 0; rsp_ready = 1; fmask = 0; req_a = 0; req_b = 0;
`ifdef CMP_SIGNED_EN
    req_signed = 0;
`endif
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 0;
    sample();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_cmp_a", cmp_a, 0);
    chk("reset_rsp_id", rsp_id, 0);
    advance();
    // single request from requester 1
    set_ops(1, 18'h2A5F3, 18'h0FFFF);
    req_valid = 3'b010;
    sample();
    chk("single_grant", req_ready, 3'b010);
    advance();
    req_valid = 0;
    sample();
    chk("single_cmp_no_rsp", rsp_valid, 0);
    advance();
    sample();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 1);
    chk("single_flags", {rsp_gt, rsp_lt, rsp_eq}, 3'b100);
    advance();
    // equal operands, issued at T+3
    set_ops(0, 18'h3FFFF, 18'h3FFFF);
    req_valid = 3'b001;
    sample();
    chk("idle_at_t3", req_ready, 3'b001);
    chk("rsp_cleared_t3", rsp_valid, 0);
    advance();
    req_valid = 0;
    cycles(1);
    sample();
    chk("equal_flags", {rsp_gt, rsp_lt, rsp_eq}, 3'b001);
    advance();
    // round robin with all requesters active from reset
    do_reset();
    gl.delete();
    gc.delete();
    for (int i = 0; i < N; i++) new_ops(i);
    req_valid = 3'b111;
    cycles(13);
    req_valid = 0;
    cycles(4);
    chk("rr_count", gl.size() >= 4, 1);
    for (int k = 0; k < 4; k++) chk("rr_order", gl[k], k % 3);
    for (int k = 1; k < 4; k++) chk("rr_spacing", gc[k] - gc[k-1], 3);
    // back-pressure with requester 2 pending
    do_reset();
    new_ops(0);
    new_ops(2);
    req_valid = 3'b101;
    sample();
    chk("bp_grant0", req_ready, 3'b001);
    advance();
    req_valid = 3'b100;
    rsp_ready = 0;
    cycles(1);
    for (int s = 0; s < 4; s++) begin
      sample();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_no_grant", req_ready, 0);
      advance();
    end
    rsp_ready = 1;
    sample();
    chk("bp_no_grant_hs", req_ready, 0);
    advance();
    sample();
    chk("bp_grant2_after", req_ready, 3'b100);
    advance();
    req_valid = 0;
    cycles(3);
    // reset while a compare is in flight
    do_reset();
    new_ops(1);
    req_valid = 3'b010;
    cycles(1);
    req_valid = 0;
    cycles(2);
    new_ops(2);
    req_valid = 3'b100;
    sample();
    chk("rc_grant2", req_ready, 3'b100);
    advance();
    req_valid = 0;
    rst = 1;
    cycles(1);
    rst = 0;
    new_ops(1);
    req_valid = 3'b110;
    sample();
    chk("rc_no_rsp", rsp_valid, 0);
    chk("rc_lowest", req_ready, 3'b010);
    advance();
    req_valid = 3'b100;
    sample();
    chk("rc_no_rsp2", rsp_valid, 0);
    advance();
    req_valid = 0;
    cycles(3);
    // signed versus unsigned on the same operands
    do_reset();
    set_ops(0, 18'h3FFFF, 18'h00001);
`ifdef CMP_SIGNED_EN
    req_signed = 3'b001;
    req_valid = 3'b001;
    cycles(1);
    req_valid = 0;
    cycles(1);
    sample();
    chk("signed_lt", {rsp_gt, rsp_lt, rsp_eq}, 3'b010);
    advance();
    req_signed = 0;
`endif
    req_valid = 3'b001;
    cycles(1);
    req_valid = 0;
    cycles(1);
    sample();
    chk("unsigned_gt", {rsp_gt, rsp_lt, rsp_eq}, 3'b100);
    advance();
    // randomized traffic, back-pressure, flag corruption and resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && last_grant == i) begin
          req_valid[i] = $urandom_range(1) == 1;
          if (req_valid[i]) new_ops(i);
        end else if (req_valid[i]) begin
          if ($urandom_range(19) == 0) req_valid[i] = 0;
        end else if ($urandom_range(2) == 0) begin
          req_valid[i] = 1;
          new_ops(i);
        end
      rsp_ready = $urandom_range(9) < 7;
      fmask = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'b000;
      rst = $urandom_range(199) == 0;
      sample();
      advance();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cmp_share_ctrl.md
# cmp_share_ctrl

Round-robin controller that time-shares one combinational 18-bit magnitude comparator among several requesters: branch-condition logic, set-less-than and the loop counter. It arbitrates requests, drives registered operands into the comparator, samples its gt/lt/eq flags one cycle later and returns them with the requester's ID over a valid/ready response channel. It sits between the processor's compare-consuming units and the single shared comparator instance.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- WIDTH, 18, operand width in bits
- ID_W, $clog2(NUM_REQ), response ID width (derived; not overridden)

Ports:
- clk  in  1  the block's only clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_signed  in  NUM_REQ  signed-compare select (present only with CMP_SIGNED_EN)
- cmp_a  out  WIDTH  registered operand to comparator; bit WIDTH-1 most significant
- cmp_b  out  WIDTH  registered operand to comparator
- cmp_gt, cmp_lt, cmp_eq  in  1 each  comparator result flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester that is being answered
- rsp_gt, rsp_lt, rsp_eq  out  1 each  registered compare result

## Operation
- The FSM has three states: IDLE, CMP and RESP.
- **IDLE:**
  - If any req_valid is set, grant the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Assert req_ready for the winner only, combinationally, in this cycle.
  - At the clock edge: latch the winner's operands into cmp_a/cmp_b, latch the winner's index into rsp_id, then go to CMP.
  - If no req_valid is set, stay in IDLE and keep req_ready at 0.
- **CMP:**
  - req_ready stays 0.
  - At the clock edge, sample cmp_gt/lt/eq into rsp_gt/lt/eq, set rsp_valid and go to RESP.
- **RESP:**
  - Hold rsp_valid and all rsp_* outputs stable until rsp_ready is 1.
  - On the handshake: clear rsp_valid, set rr_ptr = (rsp_id+1) mod NUM_REQ and go to IDLE.
- req_ready is 0 in CMP and RESP. Requests are never accepted while a transaction is in flight.
- Requesters keep req_valid and operands stable until accepted. A requester may drop req_valid before it is granted; nothing is recorded for it.
- cmp_a/cmp_b hold their last value outside transactions.
- The response carries the comparator flags exactly as sampled. The block does not fix non-one-hot flags.
- **Reset:**
  - State = IDLE, rr_ptr = 0, req_ready = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_gt/lt/eq = 0, cmp_a = cmp_b = 0.
  - A reset mid-transaction drops the in-flight compare silently; no response is issued.

## Timing
- A request accepted in cycle T gets rsp_valid in cycle T+2 (registered at the T+1 edge).
- Minimum spacing between accepts is 3 cycles (IDLE→CMP→RESP→IDLE) when rsp_ready is tied to 1.
- The comparator sees stable operands for the whole CMP cycle. Its combinational path is cmp_a/cmp_b register → comparator → rsp flop.
- Back-pressure: every cycle rsp_ready is 0 in RESP adds one cycle. No request is lost, and no other requester is granted during the stall.
- Simultaneous requests: one grant per IDLE cycle. Priority rotates so that each active requester is served within NUM_REQ transactions.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Configuration
- **CMP_SIGNED_EN defined:**
  - The req_signed port exists.
  - When the winner's req_signed is 1, bit WIDTH-1 of both operands is inverted as they are latched into cmp_a/cmp_b. This turns two's-complement ordering into unsigned ordering, so the unsigned comparator returns signed results.
  - When req_signed is 0, operands pass through unchanged.
- **CMP_SIGNED_EN undefined:**
  - The req_signed port is absent.
  - All compares are unsigned and operands pass through unmodified.

## Test plan
- **Single request:**
  - Stimulus: requester 1 has a=0x2A5F3, b=0x0FFFF; rsp_ready=1.
  - Required: req_ready[1] in T; rsp_valid in T+2 with rsp_id=1, gt=1, lt=0, eq=0; back in IDLE at T+3.
- **Equal operands:**
  - Stimulus: requester 0 has a=b=0x3FFFF.
  - Required: rsp_eq=1, gt=lt=0.
- **Round-robin:**
  - Stimulus: all three requesters hold req_valid from reset; rsp_ready=1.
  - Required: grants in order 0,1,2,0, spaced 3 cycles apart; rsp_id follows the same sequence.
- **Back-pressure:**
  - Stimulus: rsp_ready=0 for 4 cycles after rsp_valid rises, with requester 2 pending.
  - Required: rsp_* outputs stable for all 4 cycles; req_ready[2] stays 0 until the cycle after the handshake.
- **Reset in CMP:**
  - Stimulus: assert rst for 1 cycle while in CMP.
  - Required: rsp_valid never rises; rr_ptr=0; the next grant goes to the lowest-index valid requester.
- **Signed compare (CMP_SIGNED_EN):**
  - Stimulus: a=0x3FFFF (−1), b=0x00001, req_signed=1.
  - Required: lt=1.
  - Same operands with req_signed=0: gt=1.
